svc_soc_sim_ctrl: RTL

SVC_SOC_SIM_CTRL -- requirements
Module: svc_soc_sim_ctrl

---
 rtl/svc_soc_sim_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/svc_soc_sim_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | svc_soc_sim_ctrl                                                         |
// | Simulation run controller: CPU reset hold, watchdog, UART drain, result. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module svc_soc_sim_ctrl #(
  parameter int CPU_RST_CYCLES  = 16,
  parameter int WATCHDOG_CYCLES = 2_000_000,
  parameter int DRAIN_CYCLES    = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ebreak,
  input  logic        trap,
  input  logic        retire,
  input  logic [31:0] exit_code,
  input  logic        uart_busy,
  output logic        cpu_rst,
  output logic        done,
  output logic        passed,
  output logic        timeout,
  output logic        trapped,
  output logic        drain_timeout,
  output logic [31:0] exit_code_q,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  localparam logic [31:0] c_hold_last  = 32'(CPU_RST_CYCLES - 1);
  localparam logic [31:0] c_wdog_last  = 32'(WATCHDOG_CYCLES - 1);
  localparam logic [31:0] c_drain_last = 32'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] drain_cnt_q, drain_cnt_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        passed_q, passed_d;
  logic        timeout_q, timeout_d;
  logic        trapped_q, trapped_d;
  logic        drain_timeout_q, drain_timeout_d;
  logic [31:0] exit_code_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instret_count_q, instret_count_d;

  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    passed_d        = passed_q;
    timeout_d       = timeout_q;
    trapped_d       = trapped_q;
    drain_timeout_d = drain_timeout_q;
    exit_code_d     = exit_code_q;
    cycle_count_d   = cycle_count_q;
    instret_count_d = instret_count_q;

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == c_hold_last) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end

      ST_RUN: begin
        if (cycle_count_q != 32'hFFFF_FFFF) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
        if (retire && (instret_count_q != 32'hFFFF_FFFF)) begin
          instret_count_d = instret_count_q + 32'd1;
        end
        // Trap outranks ebreak, which outranks the watchdog.
        if (trap) begin
          state_d   = ST_DONE;
          trapped_d = 1'b1;
          passed_d  = 1'b0;
        end else if (ebreak) begin
          state_d     = ST_DRAIN;
          exit_code_d = exit_code;
          passed_d    = (exit_code == 32'd0);
          drain_cnt_d = 32'd0;
        end else if (cycle_count_q == c_wdog_last) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          passed_d  = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (!uart_busy) begin
          state_d = ST_DONE;
        end else if (drain_cnt_q == c_drain_last) begin
          state_d         = ST_DONE;
          drain_timeout_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = ST_DONE;
      end
    endcase

    // Outputs are registered, so they follow the state being entered.
    cpu_rst_d = (state_d == ST_HOLD) || (state_d == ST_DONE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_HOLD;
      hold_cnt_q      <= 32'd0;
      drain_cnt_q     <= 32'd0;
      cpu_rst_q       <= 1'b1;
      done_q          <= 1'b0;
      passed_q        <= 1'b0;
      timeout_q       <= 1'b0;
      trapped_q       <= 1'b0;
      drain_timeout_q <= 1'b0;
      exit_code_q     <= 32'd0;
      cycle_count_q   <= 32'd0;
      instret_count_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      cpu_rst_q       <= cpu_rst_d;
      done_q          <= done_d;
      passed_q        <= passed_d;
      timeout_q       <= timeout_d;
      trapped_q       <= trapped_d;
      drain_timeout_q <= drain_timeout_d;
      exit_code_q     <= exit_code_d;
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
    end
  end

  assign cpu_rst       = cpu_rst_q;
  assign done          = done_q;
  assign passed        = passed_q;
  assign timeout       = timeout_q;
  assign trapped       = trapped_q;
  assign drain_timeout = drain_timeout_q;
  assign cycle_count   = cycle_count_q;
  assign instret_count = instret_count_q;

endmodule
`default_nettype wire
